// File: rtl/pixel_frame_buffer_wr.sv
// AXI4 write-only slave that streams packed grayscale pixel beats into a single-port frame SRAM.
// It returns one B response per burst and counts the completed frames.
module pixel_frame_buffer_wr #(
  parameter int                DATA_W      = 256,
  parameter int                ADDR_W      = 32,
  parameter int                MST_ID_W    = 5,
  parameter int                ATX_LEN_W   = 8,
  parameter int                ATX_RESP_W  = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                FRAME_WORDS = 600,
  parameter int                MEM_ADDR_W  = 10,
  parameter int                FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [MST_ID_W-1:0]    s_awid_i,
  input  logic [ADDR_W-1:0]      s_awaddr_i,
  input  logic [ATX_LEN_W-1:0]   s_awlen_i,
  input  logic                   s_awvalid_i,
  output logic                   s_awready_o,
  input  logic [DATA_W-1:0]      s_wdata_i,
  input  logic                   s_wlast_i,
  input  logic                   s_wvalid_i,
  output logic                   s_wready_o,
  output logic [MST_ID_W-1:0]    s_bid_o,
  output logic [ATX_RESP_W-1:0]  s_bresp_o,
  output logic                   s_bvalid_o,
  input  logic                   s_bready_i,
  output logic [MEM_ADDR_W-1:0]  mem_wr_addr_o,
  output logic [DATA_W-1:0]      mem_wr_data_o,
  output logic                   mem_wr_en_o,
  input  logic                   mem_wr_rdy_i,
  output logic                   frame_done_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam logic [ATX_RESP_W-1:0] RESP_OKAY   = ATX_RESP_W'(2'b00);
  localparam logic [ATX_RESP_W-1:0] RESP_SLVERR = ATX_RESP_W'(2'b10);
  localparam logic [ATX_RESP_W-1:0] RESP_DECERR = ATX_RESP_W'(2'b11);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t                state_q;
  logic [MST_ID_W-1:0]   id_q;
  logic [ATX_LEN_W-1:0]  len_q;
  logic [ATX_LEN_W-1:0]  beat_q;
  logic [ADDR_W-1:0]     waddr_q;
  logic [ATX_RESP_W-1:0] err_q;
  logic [MEM_ADDR_W-1:0] word_q;

  logic [ADDR_W-1:0]     aw_off;
  logic [ADDR_W-1:0]     aw_waddr;
  logic                  aw_err;
  logic                  err_set;
  logic                  in_range;
  logic                  beat_ok;
  logic                  cnt_last;
  logic                  burst_end;
  logic [ATX_RESP_W-1:0] beat_err;

  assign aw_off   = s_awaddr_i - BASE_ADDR;
  assign aw_waddr = aw_off >> OFF_W;
  assign aw_err   = (s_awaddr_i < BASE_ADDR) || (s_awaddr_i[OFF_W-1:0] != '0) ||
                    (aw_waddr >= ADDR_W'(FRAME_WORDS));

  // Errored bursts are sunk at full rate; good beats wait on the SRAM.
  assign err_set       = (err_q != RESP_OKAY);
  assign in_range      = (waddr_q < ADDR_W'(FRAME_WORDS));
  assign s_wready_o    = (state_q == DATA) && (err_set || mem_wr_rdy_i);
  assign beat_ok       = s_wvalid_i && s_wready_o;
  assign mem_wr_en_o   = beat_ok && !err_set && in_range;
  assign mem_wr_addr_o = waddr_q[MEM_ADDR_W-1:0];
  assign mem_wr_data_o = s_wdata_i;

  assign cnt_last  = (beat_q == len_q);
  assign burst_end = cnt_last || s_wlast_i;

  // A beat running past the frame end wins over a wlast/length disagreement.
  always_comb begin
    beat_err = err_q;
    if (!err_set && !in_range) beat_err = RESP_DECERR;
    if ((cnt_last != s_wlast_i) && (beat_err != RESP_DECERR)) beat_err = RESP_SLVERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s_awready_o <= 1'b1;
      s_bvalid_o  <= 1'b0;
      s_bid_o     <= '0;
      s_bresp_o   <= '0;
      id_q        <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      waddr_q     <= '0;
      err_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_awvalid_i && s_awready_o) begin
            id_q        <= s_awid_i;
            len_q       <= s_awlen_i;
            beat_q      <= '0;
            waddr_q     <= aw_waddr;
            err_q       <= aw_err ? RESP_DECERR : RESP_OKAY;
            s_awready_o <= 1'b0;
            state_q     <= DATA;
          end
        end
        DATA: begin
          if (beat_ok) begin
            waddr_q <= waddr_q + 1'b1;
            beat_q  <= beat_q + 1'b1;
            err_q   <= beat_err;
            if (burst_end) begin
              s_bvalid_o <= 1'b1;
              s_bid_o    <= id_q;
              s_bresp_o  <= beat_err;
              state_q    <= RESP;
            end
          end
        end
        RESP: begin
          if (s_bready_i) begin
            s_bvalid_o  <= 1'b0;
            s_awready_o <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          s_bvalid_o  <= 1'b0;
          s_awready_o <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Frame position follows the write count, not the address, so any burst split works.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q       <= '0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      frame_done_o <= 1'b0;
      if (mem_wr_en_o) begin
        if (word_q == MEM_ADDR_W'(FRAME_WORDS - 1)) begin
          word_q       <= '0;
          frame_done_o <= 1'b1;
          frame_cnt_o  <= frame_cnt_o + 1'b1;
        end else begin
          word_q <= word_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_frame_buffer_wr.sv
// Directed self-checking bench for pixel_frame_buffer_wr.
// A negedge monitor logs every SRAM write and every frame_done pulse.
module tb_pixel_frame_buffer_wr;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic         clk;
  logic         rst;
  logic [4:0]   s_awid_i;
  logic [31:0]  s_awaddr_i;
  logic [7:0]   s_awlen_i;
  logic         s_awvalid_i;
  logic         s_awready_o;
  logic [255:0] s_wdata_i;
  logic         s_wlast_i;
  logic         s_wvalid_i;
  logic         s_wready_o;
  logic [4:0]   s_bid_o;
  logic [1:0]   s_bresp_o;
  logic         s_bvalid_o;
  logic         s_bready_i;
  logic [9:0]   mem_wr_addr_o;
  logic [255:0] mem_wr_data_o;
  logic         mem_wr_en_o;
  logic         mem_wr_rdy_i;
  logic         frame_done_o;
  logic [15:0]  frame_cnt_o;

  int n_cmp;
  int n_fail;
  int cyc;
  logic [9:0]   wr_addr[$];
  logic [255:0] wr_data[$];
  int           wr_cyc[$];
  int           done_cyc[$];

  pixel_frame_buffer_wr dut (
    .clk(clk), .rst(rst),
    .s_awid_i(s_awid_i), .s_awaddr_i(s_awaddr_i), .s_awlen_i(s_awlen_i),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wlast_i(s_wlast_i), .s_wvalid_i(s_wvalid_i),
    .s_wready_o(s_wready_o),
    .s_bid_o(s_bid_o), .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o),
    .s_bready_i(s_bready_i),
    .mem_wr_addr_o(mem_wr_addr_o), .mem_wr_data_o(mem_wr_data_o),
    .mem_wr_en_o(mem_wr_en_o), .mem_wr_rdy_i(mem_wr_rdy_i),
    .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (frame_done_o) done_cyc.push_back(cyc);
    if (mem_wr_en_o) begin
      wr_addr.push_back(mem_wr_addr_o);
      wr_data.push_back(mem_wr_data_o);
      wr_cyc.push_back(cyc);
      n_cmp++;
      if (mem_wr_rdy_i !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL write_while_not_ready: mem_wr_rdy_i=%b required 1", mem_wr_rdy_i);
      end
    end
  end

  function automatic logic [255:0] mk(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 ^ 32'(i);
    return {w, ~w, w, ~w, w + 32'd1, w, ~w, w};
  endfunction

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cyc.delete();
  endtask

  // All driving tasks start and end at posedge+2.
  task automatic do_aw(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    s_awid_i = id; s_awaddr_i = addr; s_awlen_i = len; s_awvalid_i = 1'b1;
    @(negedge clk);
    while (s_awready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n_cmp++;
    if (s_awready_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL aw_accept: awready=%b required 1", s_awready_o);
    end
    @(posedge clk); #2;
    s_awvalid_i = 1'b0;
  endtask

  task automatic do_beat(input logic [255:0] d, input logic last);
    int n;
    n = 0;
    s_wdata_i = d; s_wlast_i = last; s_wvalid_i = 1'b1;
    @(negedge clk);
    while (s_wready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (s_wready_o !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL w_accept: wready=%b required 1", s_wready_o);
    end
    @(posedge clk); #2;
    s_wvalid_i = 1'b0; s_wlast_i = 1'b0;
  endtask

  task automatic do_burst(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input int nbeats, input int seed);
    do_aw(id, addr, len);
    for (int i = 0; i < nbeats; i++) do_beat(mk(seed + i), i == nbeats - 1);
  endtask

  task automatic check_b(input string nm, input logic [4:0] id, input logic [1:0] resp);
    int n;
    n = 0;
    s_bready_i = 1'b1;
    @(negedge clk);
    while (s_bvalid_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (s_bvalid_o !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL %s_bvalid: got %b required 1", nm, s_bvalid_o);
    end else begin
      n_cmp += 2;
      if (s_bid_o !== id) begin
        n_fail++;
        $display("[TB] FAIL %s_bid: got %h required %h", nm, s_bid_o, id);
      end
      if (s_bresp_o !== resp) begin
        n_fail++;
        $display("[TB] FAIL %s_bresp: got %b required %b", nm, s_bresp_o, resp);
      end
    end
    @(posedge clk); #2;
    s_bready_i = 1'b0;
  endtask

  task automatic check_writes(input string nm, input int cnt, input int first, input int seed);
    n_cmp++;
    if (wr_addr.size() != cnt) begin
      n_fail++;
      $display("[TB] FAIL %s_wr_count: got %0d required %0d", nm, wr_addr.size(), cnt);
    end else begin
      for (int i = 0; i < cnt; i++) begin
        n_cmp += 2;
        if (wr_addr[i] !== 10'(first + i)) begin
          n_fail++;
          $display("[TB] FAIL %s_wr_addr[%0d]: got %0d required %0d", nm, i, wr_addr[i], first + i);
        end
        if (wr_data[i] !== mk(seed + i)) begin
          n_fail++;
          $display("[TB] FAIL %s_wr_data[%0d]: got %h required %h", nm, i, wr_data[i], mk(seed + i));
        end
      end
    end
  endtask

  task automatic check_reset_values(input string nm);
    n_cmp++;
    if ({s_awready_o, s_wready_o, s_bvalid_o, s_bid_o, s_bresp_o, mem_wr_en_o, mem_wr_addr_o,
         frame_done_o, frame_cnt_o} !== {1'b1, 1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 10'd0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("[TB] FAIL %s: awr=%b wr=%b bv=%b bid=%h bresp=%b en=%b addr=%0d done=%b cnt=%0d required awr=1 rest 0",
               nm, s_awready_o, s_wready_o, s_bvalid_o, s_bid_o, s_bresp_o, mem_wr_en_o,
               mem_wr_addr_o, frame_done_o, frame_cnt_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset_values");
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    clear_log();
    do_burst(5'h15, BASE, 8'd3, 4, 0);
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (s_bvalid_o !== 1'b1 || s_bid_o !== 5'h15) begin
        n_fail++;
        $display("[TB] FAIL basic_b_hold: bvalid=%b bid=%h required 1 15", s_bvalid_o, s_bid_o);
      end
    end
    @(posedge clk); #2;
    check_b("basic", 5'h15, 2'b00);
    check_writes("basic", 4, 0, 0);
  endtask

  task automatic test_backpressure();
    logic rdy_pat [4];
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    clear_log();
    do_aw(5'h02, BASE + 32'd4 * 32, 8'd1);
    s_wvalid_i = 1'b1; s_wdata_i = mk(100); s_wlast_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_wr_rdy_i = rdy_pat[i];
      if (i == 1) begin s_wdata_i = mk(101); s_wlast_i = 1'b1; end
      @(negedge clk);
      n_cmp++;
      if (s_wready_o !== rdy_pat[i]) begin
        n_fail++;
        $display("[TB] FAIL bp_wready[%0d]: got %b required %b", i, s_wready_o, rdy_pat[i]);
      end
      @(posedge clk); #2;
    end
    s_wvalid_i = 1'b0; s_wlast_i = 1'b0; mem_wr_rdy_i = 1'b1;
    check_b("bp", 5'h02, 2'b00);
    check_writes("bp", 2, 4, 100);
  endtask

  task automatic test_decerr();
    clear_log();
    mem_wr_rdy_i = 1'b0;
    do_burst(5'h07, BASE + 32'd600 * 32, 8'd3, 4, 200);
    mem_wr_rdy_i = 1'b1;
    check_b("dec_past_end", 5'h07, 2'b11);
    check_writes("dec_past_end", 0, 0, 0);
    do_burst(5'h08, BASE + 32'd598 * 32, 8'd3, 4, 300);
    check_b("dec_overflow", 5'h08, 2'b11);
    check_writes("dec_overflow", 2, 598, 300);
    clear_log();
    do_burst(5'h09, BASE - 32'd32, 8'd0, 1, 400);
    check_b("dec_below", 5'h09, 2'b11);
    do_burst(5'h0A, BASE + 32'd4, 8'd0, 1, 410);
    check_b("dec_unaligned", 5'h0A, 2'b11);
    check_writes("dec_below_unaligned", 0, 0, 0);
  endtask

  task automatic test_slverr();
    clear_log();
    do_burst(5'h0C, BASE + 32'd10 * 32, 8'd3, 2, 500);
    check_b("slverr", 5'h0C, 2'b10);
    check_writes("slverr", 2, 10, 500);
    clear_log();
    do_burst(5'h0D, BASE + 32'd12 * 32, 8'd0, 1, 510);
    check_b("after_slverr", 5'h0D, 2'b00);
    check_writes("after_slverr", 1, 12, 510);
  endtask

  task automatic test_mid_reset();
    logic bv_seen;
    do_aw(5'h1F, BASE + 32'd20 * 32, 8'd7);
    for (int i = 0; i < 3; i++) do_beat(mk(600 + i), 1'b0);
    s_wvalid_i = 1'b1; s_wdata_i = mk(603); rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("mid_reset_values");
    @(posedge clk); #2;
    rst = 1'b0; s_wvalid_i = 1'b0;
    s_bready_i = 1'b1;
    bv_seen = 1'b0;
    repeat (5) begin @(negedge clk); bv_seen |= s_bvalid_o; end
    n_cmp++;
    if (bv_seen !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_no_b: bvalid seen %b required 0", bv_seen);
    end
    @(posedge clk); #2;
    s_bready_i = 1'b0;
    clear_log();
    do_burst(5'h03, BASE + 32'd30 * 32, 8'd0, 1, 700);
    check_b("post_reset", 5'h03, 2'b00);
    check_writes("post_reset", 1, 30, 700);
  endtask

  task automatic test_frame();
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    clear_log();
    for (int f = 1; f <= 2; f++) begin
      for (int b = 0; b < 10; b++) begin
        do_burst(5'(b), BASE + 32'(b * 60 * 32), 8'd59, 60, b * 60);
        check_b("frame_burst", 5'(b), 2'b00);
      end
      repeat (2) @(posedge clk);
      #2;
      n_cmp++;
      if (wr_cyc.size() != 600 * f || done_cyc.size() != f) begin
        n_fail++;
        $display("[TB] FAIL frame%0d_counts: writes=%0d pulses=%0d required %0d %0d",
                 f, wr_cyc.size(), done_cyc.size(), 600 * f, f);
      end else begin
        n_cmp++;
        if (done_cyc[f-1] != wr_cyc[600*f-1] + 1) begin
          n_fail++;
          $display("[TB] FAIL frame%0d_pulse_cycle: got %0d required %0d",
                   f, done_cyc[f-1], wr_cyc[600*f-1] + 1);
        end
      end
      n_cmp++;
      if (frame_cnt_o !== 16'(f)) begin
        n_fail++;
        $display("[TB] FAIL frame%0d_cnt: got %0d required %0d", f, frame_cnt_o, f);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    s_awid_i = '0; s_awaddr_i = '0; s_awlen_i = '0; s_awvalid_i = 1'b0;
    s_wdata_i = '0; s_wlast_i = 1'b0; s_wvalid_i = 1'b0;
    s_bready_i = 1'b0; mem_wr_rdy_i = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_decerr();
    test_slverr();
    test_mid_reset();
    test_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
